// File: rtl/datapath_gearbox_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : datapath_gearbox_fifo_if
// Brief    : Write/read/status bundle of the lane-granular gearbox FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface datapath_gearbox_fifo_if #(
    parameter int LANE_WIDTH = 64,
    parameter int IN_LANES   = 2,
    parameter int OUT_LANES  = 3,
    parameter int ADDR_W     = 10
);
    localparam int c_NL_W = $clog2(IN_LANES + 1);

    logic                            wr;
    logic [c_NL_W-1:0]               wr_nlanes;
    logic [IN_LANES*LANE_WIDTH-1:0]  data_in;
    logic                            rd;
    logic                            clr_err;
    logic [OUT_LANES*LANE_WIDTH-1:0] data_out;
    logic                            rd_valid;
    logic [ADDR_W:0]                 data_count;
    logic                            full;
    logic                            empty;
    logic                            threshold;
    logic                            overflow;
    logic                            underflow;

    modport master (
        output wr, wr_nlanes, data_in, rd, clr_err,
        input  data_out, rd_valid, data_count, full, empty, threshold, overflow, underflow
    );

    modport slave (
        input  wr, wr_nlanes, data_in, rd, clr_err,
        output data_out, rd_valid, data_count, full, empty, threshold, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/datapath_gearbox_fifo.sv
`default_nettype none
// ============================================================================
// Module   : datapath_gearbox_fifo
// Brief    : Variable-lane write, fixed OUT_LANES paced read width-converting FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_gearbox_fifo #(
    parameter int LANE_WIDTH = 64,
    parameter int IN_LANES   = 2,
    parameter int OUT_LANES  = 3,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int RD_DIV     = 30,
    parameter int THRESHOLD  = 512
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    datapath_gearbox_fifo_if.slave bus
);
    localparam int                    c_NL_W      = $clog2(IN_LANES + 1);
    localparam int                    c_TICK_W    = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
    localparam logic [c_TICK_W-1:0]   c_TICK_LAST = c_TICK_W'(RD_DIV - 1);
    localparam logic [ADDR_W:0]       c_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]       c_IN        = (ADDR_W + 1)'(IN_LANES);
    localparam logic [ADDR_W:0]       c_OUT       = (ADDR_W + 1)'(OUT_LANES);
    localparam logic [ADDR_W:0]       c_THR       = (ADDR_W + 1)'(THRESHOLD);

    logic [LANE_WIDTH-1:0]           r_mem [DEPTH];
    logic [ADDR_W-1:0]               r_wptr;
    logic [ADDR_W-1:0]               r_rptr;
    logic [ADDR_W:0]                 r_count;
    logic [c_TICK_W-1:0]             r_tick_cnt;
    logic [OUT_LANES*LANE_WIDTH-1:0] r_data_out;
    logic                            r_rd_valid;
    logic                            r_overflow;
    logic                            r_underflow;

    logic                            w_tick;
    logic [ADDR_W:0]                 w_free;
    logic [ADDR_W:0]                 w_nlanes;
    logic                            w_wr_req;
    logic                            w_wr_acc;
    logic                            w_rd_req;
    logic                            w_rd_acc;
    logic [ADDR_W:0]                 w_count_nxt;
    logic [OUT_LANES*LANE_WIDTH-1:0] w_rd_word;

    assign w_tick      = (r_tick_cnt == c_TICK_LAST);
    assign w_free      = c_DEPTH - r_count;
    assign w_nlanes    = (ADDR_W + 1)'(bus.wr_nlanes);
    assign w_wr_req    = bus.wr && (bus.wr_nlanes != '0);
    // Both acceptances look at the start-of-cycle count, so a read never frees
    // space for a same-cycle write and never returns same-cycle written lanes.
    assign w_wr_acc    = w_wr_req && (w_nlanes <= w_free);
    assign w_rd_req    = bus.rd && w_tick;
    assign w_rd_acc    = w_rd_req && (r_count >= c_OUT);
    assign w_count_nxt = r_count + (w_wr_acc ? w_nlanes : '0) - (w_rd_acc ? c_OUT : '0);

    // Each RAM row picks up whichever input lane lands on it this cycle.
    for (genvar a = 0; a < DEPTH; a++) begin : g_row
        logic                  w_we;
        logic [LANE_WIDTH-1:0] w_din;

        always_comb begin
            w_we  = 1'b0;
            w_din = '0;
            for (int k = 0; k < IN_LANES; k++) begin
                if (w_wr_acc && (c_NL_W'(k) < bus.wr_nlanes) &&
                    ((r_wptr + ADDR_W'(k)) == ADDR_W'(a))) begin
                    w_we  = 1'b1;
                    w_din = bus.data_in[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[a] <= w_din;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            w_rd_word[j*LANE_WIDTH +: LANE_WIDTH] = r_mem[r_rptr + ADDR_W'(j)];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_tick_cnt  <= '0;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_TICK_W'(1);
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wptr <= r_wptr + w_nlanes[ADDR_W-1:0];
            end
            if (w_rd_acc) begin
                r_rptr     <= r_rptr + c_OUT[ADDR_W-1:0];
                r_data_out <= w_rd_word;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            if (w_wr_req && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_req && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.data_count = r_count;
    assign bus.full       = (w_free < c_IN);
    assign bus.empty      = (r_count < c_OUT);
    assign bus.threshold  = (r_count >= c_THR);
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_datapath_gearbox_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_gearbox_fifo
// Brief    : Self-checking bench for the gearbox FIFO with a lane-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_gearbox_fifo;
    localparam int LW     = 16;
    localparam int IL     = 2;
    localparam int OL     = 3;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int RD_DIV = 4;
    localparam int THR    = 5;
    localparam int NLW    = $clog2(IL + 1);

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    datapath_gearbox_fifo_if #(.LANE_WIDTH(LW), .IN_LANES(IL), .OUT_LANES(OL), .ADDR_W(AW)) bus ();

    datapath_gearbox_fifo #(
        .LANE_WIDTH(LW), .IN_LANES(IL), .OUT_LANES(OL), .DEPTH(DEPTH),
        .ADDR_W(AW), .RD_DIV(RD_DIV), .THRESHOLD(THR)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the FIFO is a queue of lanes, pacing is cycle index mod RD_DIV.
    logic [LW-1:0]    mq[$];
    logic [OL*LW-1:0] m_dout;
    bit               m_rv, m_ovf, m_unf;
    int               m_cyc;

    typedef struct {
        logic           wr;
        int             n;
        logic [IL*LW-1:0] d;
        logic           rd;
        logic           clr;
        int             exp_count;
        logic           exp_rv;
        logic           exp_ovf;
        logic           exp_unf;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count",     64'(bus.data_count), 64'(mq.size()));
        check("full",      64'(bus.full),       64'((DEPTH - mq.size()) < IL));
        check("empty",     64'(bus.empty),      64'(mq.size() < OL));
        check("threshold", 64'(bus.threshold),  64'(mq.size() >= THR));
        check("overflow",  64'(bus.overflow),   64'(m_ovf));
        check("underflow", 64'(bus.underflow),  64'(m_unf));
        check("rd_valid",  64'(bus.rd_valid),   64'(m_rv));
        check("data_out",  64'(bus.data_out),   64'(m_dout));
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_rv   = 0;
        m_ovf  = 0;
        m_unf  = 0;
        m_cyc  = 0;
    endtask

    task automatic step(input logic w, input int n, input logic [IL*LW-1:0] d,
                        input logic r, input logic c);
        int cnt;
        bit tick, wacc, racc;
        bus.wr        = w;
        bus.wr_nlanes = NLW'(n);
        bus.data_in   = d;
        bus.rd        = r;
        bus.clr_err   = c;
        @(posedge clk);
        cnt  = mq.size();
        tick = (m_cyc % RD_DIV) == RD_DIV - 1;
        wacc = w && n != 0 && n <= DEPTH - cnt;
        racc = r && tick && cnt >= OL;
        m_rv = racc;
        if (racc) for (int j = 0; j < OL; j++) m_dout[j*LW +: LW] = mq.pop_front();
        if (wacc) for (int k = 0; k < n; k++) mq.push_back(d[k*LW +: LW]);
        if (w && n != 0 && !wacc) m_ovf = 1; else if (c) m_ovf = 0;
        if (r && tick && !racc)   m_unf = 1; else if (c) m_unf = 0;
        m_cyc++;
        #1;
        check_all();
    endtask

    task automatic idle_to_tick();
        while ((m_cyc % RD_DIV) != RD_DIV - 1) step(0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        #2;
        rstn          = 1'b0;
        bus.wr        = 1'b0;
        bus.wr_nlanes = '0;
        bus.data_in   = '0;
        bus.rd        = 1'b0;
        bus.clr_err   = 1'b0;
        #1;
        model_reset();
        check("rst_count", 64'(bus.data_count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_dout",  64'(bus.data_out), 64'd0);
        check("rst_flags", 64'({bus.rd_valid, bus.full, bus.threshold, bus.overflow, bus.underflow}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_vec(input int i);
        step(vecs[i].wr, vecs[i].n, vecs[i].d, vecs[i].rd, vecs[i].clr);
        check($sformatf("vec%0d_count", i), 64'(bus.data_count), 64'(vecs[i].exp_count));
        check($sformatf("vec%0d_rv", i),    64'(bus.rd_valid),   64'(vecs[i].exp_rv));
        check($sformatf("vec%0d_ovf", i),   64'(bus.overflow),   64'(vecs[i].exp_ovf));
        check($sformatf("vec%0d_unf", i),   64'(bus.underflow),  64'(vecs[i].exp_unf));
        if (i == 3) check("vec3_dout", 64'(bus.data_out), 64'({16'hB000, 16'hA001, 16'hA000}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          wr  n  data                   rd clr cnt rv ovf unf
        vecs[0]  = '{1, 2, {16'hA001, 16'hA000}, 0, 0, 2, 0, 0, 0};
        vecs[1]  = '{1, 1, {16'hDEAD, 16'hB000}, 1, 0, 3, 0, 0, 0};
        vecs[2]  = '{0, 0, 32'h0,                1, 0, 3, 0, 0, 0};
        vecs[3]  = '{0, 0, 32'h0,                1, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 32'h0,                0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 2, {16'h0011, 16'h0010}, 0, 0, 2, 0, 0, 0};
        vecs[6]  = '{1, 2, {16'h0013, 16'h0012}, 0, 0, 4, 0, 0, 0};
        vecs[7]  = '{1, 2, {16'h0015, 16'h0014}, 0, 0, 6, 0, 0, 0};
        vecs[8]  = '{1, 2, {16'h0017, 16'h0016}, 0, 0, 8, 0, 0, 0};
        vecs[9]  = '{1, 2, {16'h0019, 16'h0018}, 0, 0, 8, 0, 1, 0};
        vecs[10] = '{0, 0, 32'h0,                0, 1, 8, 0, 0, 0};
        vecs[11] = '{0, 0, 32'h0,                1, 0, 5, 1, 0, 0};
        vecs[12] = '{1, 0, {16'h0EEE, 16'h0EEE}, 0, 0, 5, 0, 0, 0};

        // Basic gearbox, fill to full, overflow and clear.
        do_reset();
        for (int i = 0; i < 13; i++) run_vec(i);
        check("vec_full_read", 64'(bus.data_out), 64'({16'h0012, 16'h0011, 16'h0010}));

        // Pacing: rd held high, valid only on cycles RD_DIV-1 and 2*RD_DIV-1.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 3) step(1, 2, {16'(2*c+1), 16'(2*c)}, 1, 0);
            else       step(0, 0, '0, 1, 0);
            check($sformatf("pace_rv_c%0d", c), 64'(bus.rd_valid), 64'(c == 3 || c == 7));
        end

        // Pointer wrap across the address boundary.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 2, {16'(2*i+1), 16'(2*i)}, 0, 0);
        idle_to_tick(); step(0, 0, '0, 1, 0);
        check("wrap_rd0", 64'(bus.data_out), 64'({16'd2, 16'd1, 16'd0}));
        for (int i = 3; i < 5; i++) step(1, 2, {16'(2*i+1), 16'(2*i)}, 0, 0);
        idle_to_tick(); step(0, 0, '0, 1, 0);
        check("wrap_rd1", 64'(bus.data_out), 64'({16'd5, 16'd4, 16'd3}));
        idle_to_tick(); step(0, 0, '0, 1, 0);
        check("wrap_rd2", 64'(bus.data_out), 64'({16'd8, 16'd7, 16'd6}));
        check("wrap_cnt", 64'(bus.data_count), 64'd1);

        // Simultaneous read and write, then a rejected ticked read with clear.
        step(1, 2, {16'd11, 16'd10}, 0, 0);
        step(1, 1, {16'hFFFF, 16'd12}, 0, 0);
        idle_to_tick(); step(1, 2, {16'd14, 16'd13}, 1, 0);
        check("simul_cnt",  64'(bus.data_count), 64'd3);
        check("simul_dout", 64'(bus.data_out), 64'({16'd11, 16'd10, 16'd9}));
        idle_to_tick(); step(0, 0, '0, 1, 0);
        check("simul_rd2",  64'(bus.data_out), 64'({16'd14, 16'd13, 16'd12}));
        step(1, 2, {16'd16, 16'd15}, 0, 0);
        idle_to_tick(); step(0, 0, '0, 1, 1);
        check("unf_setwins", 64'(bus.underflow), 64'd1);
        check("unf_cnt",     64'(bus.data_count), 64'd2);
        step(0, 0, '0, 0, 1);
        check("unf_clr", 64'(bus.underflow), 64'd0);

        // Reset in the middle of traffic with count 5 and overflow set.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2, {16'(i+32), 16'(i+16)}, 0, 0);
        step(1, 2, '1, 0, 0);
        idle_to_tick(); step(0, 0, '0, 1, 0);
        check("mid_cnt5", 64'(bus.data_count), 64'd5);
        check("mid_ovf",  64'(bus.overflow), 64'd1);
        do_reset();
        for (int i = 0; i < 5; i++) run_vec(i);

        // Randomized traffic against the lane-queue model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, int'($urandom_range(0, IL)), (IL*LW)'($urandom),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
